frame_commit_controller: RTL

//  Sequences the thermostat frame decoder: arms it on transmission_begin, waits for a frame-complete

---
 rtl/frame_commit_controller_pkg.sv | 23 ++
 rtl/frame_commit_controller_saturating_counter.sv | 19 +
 rtl/frame_commit_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/frame_commit_controller_pkg.sv
// Shared types and defaults for the thermostat frame commit controller.
// Field defaults describe the only frame layout the decoder accepts today.
package frame_commit_controller_pkg;

    localparam int unsigned COUNT_W = 8;
    localparam int unsigned WD_W    = 20;

    localparam logic [31:0]     DEF_EXP_PREAMBLE = 32'hAAAA_AAAA;
    localparam logic [15:0]     DEF_EXP_TYPE_1   = 16'h0000;
    localparam logic [15:0]     DEF_EXP_TYPE_2   = 16'h0000;
    localparam logic [31:0]     DEF_EXP_CONSTANT = 32'h0000_0000;
    localparam logic [WD_W-1:0] DEF_TIMEOUT      = 20'd100000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_CHECK   = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_REJECT  = 3'd4,
        ST_FLUSH   = 3'd5
    } fsm_t;

endpackage

// File: rtl/frame_commit_controller_saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_commit_controller.sv
// Arms the thermostat frame decoder, validates the fixed fields of each completed
// frame and commits good payloads to held output registers.
module frame_commit_controller
    import frame_commit_controller_pkg::*;
#(
    parameter logic [31:0]     EXP_PREAMBLE = DEF_EXP_PREAMBLE,
    parameter logic [15:0]     EXP_TYPE_1   = DEF_EXP_TYPE_1,
    parameter logic [15:0]     EXP_TYPE_2   = DEF_EXP_TYPE_2,
    parameter logic [31:0]     EXP_CONSTANT = DEF_EXP_CONSTANT,
    parameter logic [WD_W-1:0] TIMEOUT      = DEF_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               transmission_begin,
    input  logic               bit_strobe,
    input  logic               full,
    input  logic [31:0]        preamble,
    input  logic [15:0]        type_1,
    input  logic [15:0]        type_2,
    input  logic [31:0]        constant,
    input  logic [31:0]        thermostat_id,
    input  logic [15:0]        room_temp,
    input  logic [15:0]        set_temp,
    input  logic [7:0]         state,
    output logic               decoder_flush,
    output logic               frame_valid,
    output logic               have_frame,
    output logic               rx_busy,
    output logic [31:0]        id_q,
    output logic [15:0]        room_q,
    output logic [15:0]        set_q,
    output logic [7:0]         state_q,
    output logic [COUNT_W-1:0] good_count,
    output logic [COUNT_W-1:0] bad_count
);

    fsm_t            fsm;
    logic [WD_W-1:0] watchdog;
    logic            full_d;

    // Compare stage: fields frozen on the frame-complete edge.
    logic [31:0] cap_preamble;
    logic [15:0] cap_type_1;
    logic [15:0] cap_type_2;
    logic [31:0] cap_constant;
    logic [31:0] cap_id;
    logic [15:0] cap_room;
    logic [15:0] cap_set;
    logic [7:0]  cap_state;

    logic full_edge;
    logic timeout_hit;
    logic fields_ok;
    logic good_inc;
    logic bad_inc;

    assign full_edge = full && !full_d;

    // Restart and a fresh frame both outrank the watchdog expiring.
    assign timeout_hit = (fsm == ST_RECEIVE) && !transmission_begin && !full_edge &&
                         !bit_strobe && (watchdog == TIMEOUT - 20'd1);

    assign fields_ok = (cap_preamble == EXP_PREAMBLE) && (cap_type_1 == EXP_TYPE_1) &&
                       (cap_type_2 == EXP_TYPE_2) && (cap_constant == EXP_CONSTANT);

    assign good_inc = (fsm == ST_COMMIT);
    assign bad_inc  = (fsm == ST_REJECT) || timeout_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm           <= ST_IDLE;
            watchdog      <= '0;
            full_d        <= 1'b0;
            decoder_flush <= 1'b0;
            frame_valid   <= 1'b0;
            have_frame    <= 1'b0;
            rx_busy       <= 1'b0;
            id_q          <= '0;
            room_q        <= '0;
            set_q         <= '0;
            state_q       <= '0;
            cap_preamble  <= '0;
            cap_type_1    <= '0;
            cap_type_2    <= '0;
            cap_constant  <= '0;
            cap_id        <= '0;
            cap_room      <= '0;
            cap_set       <= '0;
            cap_state     <= '0;
        end else begin
            full_d        <= full;
            frame_valid   <= 1'b0;
            decoder_flush <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (transmission_begin) begin
                        fsm      <= ST_RECEIVE;
                        watchdog <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    if (transmission_begin) begin
                        watchdog <= '0;
                    end else if (full_edge) begin
                        fsm          <= ST_CHECK;
                        watchdog     <= '0;
                        cap_preamble <= preamble;
                        cap_type_1   <= type_1;
                        cap_type_2   <= type_2;
                        cap_constant <= constant;
                        cap_id       <= thermostat_id;
                        cap_room     <= room_temp;
                        cap_set      <= set_temp;
                        cap_state    <= state;
                    end else if (bit_strobe) begin
                        watchdog <= '0;
                    end else if (timeout_hit) begin
                        fsm      <= ST_FLUSH;
                        watchdog <= '0;
                        rx_busy  <= 1'b0;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ST_CHECK: begin
                    fsm     <= fields_ok ? ST_COMMIT : ST_REJECT;
                    rx_busy <= 1'b0;
                end
                ST_COMMIT: begin
                    id_q        <= cap_id;
                    room_q      <= cap_room;
                    set_q       <= cap_set;
                    state_q     <= cap_state;
                    frame_valid <= 1'b1;
                    have_frame  <= 1'b1;
                    fsm         <= ST_FLUSH;
                end
                ST_REJECT: begin
                    fsm <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    decoder_flush <= 1'b1;
                    fsm           <= ST_IDLE;
                end
                default: begin
                    fsm     <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    saturating_counter #(.WIDTH(COUNT_W)) u_good_count (
        .clock (clock),
        .reset (reset),
        .inc   (good_inc),
        .count (good_count)
    );

    saturating_counter #(.WIDTH(COUNT_W)) u_bad_count (
        .clock (clock),
        .reset (reset),
        .inc   (bad_inc),
        .count (bad_count)
    );

endmodule
